// File: rtl/bit_sel_ctrl.sv
// Sequencer for the 450-to-128 reliable-bit selector: loads index/b, scans until the
// selector reports done, then hands the selected vector downstream via valid/ready.
module bit_sel_ctrl #(
    parameter int N_BITS = 450,
    parameter int N_SEL  = 128,
    parameter int CNT_W  = 9
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             abort,
    input  logic             err_clr,
    output logic             sel_load_idx,
    output logic             sel_load_b,
    output logic             sel_en,
    input  logic             sel_done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             error,
    output logic [CNT_W-1:0] scan_cnt
);

    generate
        if (N_SEL > N_BITS || (1 << CNT_W) <= N_BITS) begin : g_bad_cfg
            $error("bit_sel_ctrl: N_SEL must not exceed N_BITS and 2**CNT_W must exceed N_BITS");
        end
    endgenerate

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(N_BITS);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SCAN,
        HOLD,
        ERR
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt_nxt;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            scan_cnt <= '0;
        end else begin
            state    <= state_nxt;
            scan_cnt <= cnt_nxt;
        end
    end

    // The selector's done flag stops shifting in the same cycle it is seen.
    assign sel_en = (state == SCAN) && !sel_done && (scan_cnt < MAX_CNT);

    // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
    always_comb begin
        state_nxt = state;
        cnt_nxt   = scan_cnt;

        case (state)
            IDLE: if (start && !abort) state_nxt = LOAD;
            LOAD: state_nxt = SCAN;
            SCAN: begin
                if (sel_done)                 state_nxt = HOLD;
                else if (scan_cnt == MAX_CNT) state_nxt = ERR;
            end
            HOLD: if (out_ready) state_nxt = IDLE;
            ERR:  if (err_clr)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        if (abort && state != IDLE) state_nxt = IDLE;

        // Count is zero whenever a run is not in progress, and freezes in HOLD/ERR.
        if (state_nxt == IDLE || state_nxt == LOAD) cnt_nxt = '0;
        else if (sel_en)                            cnt_nxt = scan_cnt + CNT_W'(1);
    end

    assign sel_load_idx = (state == LOAD);
    assign sel_load_b   = (state == LOAD);
    assign out_valid    = (state == HOLD);
    assign busy         = (state != IDLE);
    assign error        = (state == ERR);

endmodule

// File: tb/tb_bit_sel_ctrl.sv
// Bench for bit_sel_ctrl: a behavioural selector drives sel_done, a queue-based
// scoreboard holds expected results computed directly from the index/b vectors.
module tb_bit_sel_ctrl;

    localparam int N_BITS = 450;
    localparam int N_SEL  = 128;
    localparam int CNT_W  = 9;

    logic clk = 1'b0;
    logic resetn, start, abort, err_clr, out_ready;
    logic sel_load_idx, sel_load_b, sel_en, sel_done, out_valid, busy, error;
    logic [CNT_W-1:0] scan_cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    bit_sel_ctrl #(.N_BITS(N_BITS), .N_SEL(N_SEL), .CNT_W(CNT_W)) dut (
        .clk(clk), .resetn(resetn), .start(start), .abort(abort), .err_clr(err_clr),
        .sel_load_idx(sel_load_idx), .sel_load_b(sel_load_b), .sel_en(sel_en),
        .sel_done(sel_done), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .error(error), .scan_cnt(scan_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural selector: walks index from MSB, shifting in b bits where index is 1.
    logic [N_BITS-1:0] idx_in, b_in, idx_r, b_r;
    logic [N_SEL-1:0]  sel_vec;
    int                ptr, got;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            idx_r <= '0; b_r <= '0; sel_vec <= '0; ptr <= N_BITS - 1; got <= 0; sel_done <= 1'b0;
        end else if (sel_load_idx || sel_load_b) begin
            if (sel_load_idx) idx_r <= idx_in;
            if (sel_load_b)   b_r   <= b_in;
            sel_vec <= '0; ptr <= N_BITS - 1; got <= 0; sel_done <= 1'b0;
        end else if (sel_en && !sel_done && ptr >= 0) begin
            if (idx_r[ptr]) begin
                sel_vec <= {sel_vec[N_SEL-2:0], b_r[ptr]};
                got     <= got + 1;
                if (got + 1 == N_SEL) sel_done <= 1'b1;
            end
            ptr <= ptr - 1;
        end
    end

    typedef struct {
        logic             err;
        logic [N_SEL-1:0] vec;
        int               cnt;
        int               at;
    } exp_t;

    exp_t exp_q[$];

    // Expected outcome: the N_SEL-th one from the MSB fixes the scan length k.
    function automatic exp_t model(input logic [N_BITS-1:0] idx, input logic [N_BITS-1:0] b, input int c0);
        exp_t e;
        int   n = 0;
        e.err = 1'b1; e.vec = '0; e.cnt = N_BITS; e.at = c0 + N_BITS + 3;
        for (int i = N_BITS - 1; i >= 0; i--) begin
            if (idx[i]) begin
                e.vec[N_SEL-1-n] = b[i];
                n++;
                if (n == N_SEL) begin
                    e.err = 1'b0; e.cnt = N_BITS - i; e.at = c0 + e.cnt + 3;
                    break;
                end
            end
        end
        return e;
    endfunction

    // Monitor: samples just after the falling edge, when inputs for the next edge are set.
    logic prev_v = 1'b0, prev_e = 1'b0;
    exp_t cur;

    always begin
        @(negedge clk);
        #1;
        if (out_valid && !prev_v) begin
            if (exp_q.size() == 0) check("unexpected_valid", 1, 0);
            else begin
                cur = exp_q.pop_front();
                check("valid_not_err", cur.err, 0);
                check("valid_cycle", cyc, cur.at);
                check("scan_cnt_hold", scan_cnt, cur.cnt);
            end
        end
        if (error && !prev_e) begin
            if (exp_q.size() == 0) check("unexpected_error", 1, 0);
            else begin
                cur = exp_q.pop_front();
                check("err_expected", cur.err, 1);
                check("err_cycle", cyc, cur.at);
                check("scan_cnt_err", scan_cnt, cur.cnt);
            end
        end
        if (out_valid) begin
            check("hold_sel_en", sel_en, 0);
            check("hold_vec", sel_vec, cur.vec);
        end
        if (sel_done && busy) check("en_while_done", sel_en, 0);
        if (busy) check("cnt_bound", scan_cnt > N_BITS, 0);
        prev_v = out_valid;
        prev_e = error;
    end

    function automatic logic [N_BITS-1:0] rand_vec();
        logic [N_BITS-1:0] v;
        for (int i = 0; i < N_BITS; i++) v[i] = 1'($urandom % 2);
        return v;
    endfunction

    function automatic logic [N_BITS-1:0] rand_idx(input int pct);
        logic [N_BITS-1:0] v;
        for (int i = 0; i < N_BITS; i++) v[i] = ($urandom_range(99) < pct);
        return v;
    endfunction

    function automatic logic [N_BITS-1:0] leading_ones(input int n);
        logic [N_BITS-1:0] v = '0;
        for (int i = 0; i < n; i++) v[N_BITS-1-i] = 1'b1;
        return v;
    endfunction

    task automatic do_start(input logic [N_BITS-1:0] idx, input logic [N_BITS-1:0] b);
        @(negedge clk);
        idx_in = idx; b_in = b; start = 1'b1;
        exp_q.push_back(model(idx, b, cyc));
        @(negedge clk);
        start = 1'b0;
        check("load_idx_pulse", sel_load_idx, 1);
        check("load_b_pulse", sel_load_b, 1);
        check("busy_in_load", busy, 1);
    endtask

    task automatic finish_run(input int hold);
        int n = 0;
        while (!(out_valid || error) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!(out_valid || error)) begin
            check("run_timeout", 0, 1);
            return;
        end
        if (out_valid) begin
            repeat (hold) @(negedge clk);
            check("valid_held", out_valid, 1);
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            check("idle_after_ready", {busy, out_valid}, 0);
        end else begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check("err_ignores_start", {error, out_valid}, 2'b10);
            err_clr = 1'b1;
            @(negedge clk);
            err_clr = 1'b0;
            check("idle_after_clr", {busy, error, scan_cnt}, 0);
        end
    endtask

    task automatic wait_cnt(input int target);
        int n = 0;
        while (scan_cnt != CNT_W'(target) && n < 600) begin
            @(negedge clk);
            n++;
        end
        check("reach_scan_cnt", scan_cnt, target);
    endtask

    logic [N_BITS-1:0] bb, ii;
    int                en_seen;

    initial begin
        resetn = 1'b0; start = 1'b0; abort = 1'b0; err_clr = 1'b0; out_ready = 1'b0;
        idx_in = '0; b_in = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_outputs", {sel_load_idx, sel_load_b, sel_en, out_valid, error}, 0);
        check("rst_scan_cnt", scan_cnt, 0);
        resetn = 1'b1;

        // start and abort together in IDLE stay idle
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("start_abort_idle", {busy, sel_load_idx}, 0);

        // 128 leading ones: selected vector is the top 128 bits of b
        bb = rand_vec();
        do_start(leading_ones(N_SEL), bb);
        finish_run(0);
        check("lead_vec", sel_vec, bb[N_BITS-1 -: N_SEL]);

        // 128 ones in the LSBs: full-length scan ending in HOLD
        ii = '0;
        for (int i = 0; i < N_SEL; i++) ii[i] = 1'b1;
        do_start(ii, rand_vec());
        finish_run(0);

        // 127 ones: error, then a clean run afterwards
        ii = '0;
        for (int i = 0; i < N_SEL - 1; i++) ii[i * 3] = 1'b1;
        do_start(ii, rand_vec());
        finish_run(0);
        do_start(leading_ones(N_SEL + 5), rand_vec());
        finish_run(0);

        // consumer stalls 20 cycles in HOLD
        do_start(rand_idx(60), rand_vec());
        finish_run(20);

        // abort mid-scan, then restart with a fresh index/b
        do_start(leading_ones(N_SEL), rand_vec());
        wait_cnt(60);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_idle", {busy, sel_en, out_valid, error}, 0);
        check("abort_cnt_clear", scan_cnt, 0);
        void'(exp_q.pop_back());
        do_start(rand_idx(50), rand_vec());
        finish_run(2);

        // reset during SCAN
        do_start(rand_idx(40), rand_vec());
        wait_cnt(30);
        resetn = 1'b0;
        #1;
        check("rst_mid_outputs", {busy, sel_en, sel_load_idx, sel_load_b, out_valid, error}, 0);
        check("rst_mid_cnt", scan_cnt, 0);
        void'(exp_q.pop_back());
        @(negedge clk);
        resetn = 1'b1;
        en_seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (sel_en || busy) en_seen++;
        end
        check("no_en_after_reset", en_seen, 0);

        // randomized runs around the reliable-bit threshold
        for (int r = 0; r < 30; r++) begin
            do_start(rand_idx($urandom_range(40, 20)), rand_vec());
            finish_run($urandom_range(3));
        end

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
